tile_fb_controller: RTL

- Owns the single-port tile framebuffer RAM (32x24 tiles, 8-bit RRRGGGBB colour per tile) and arbitrates one access per cycle between three requesters.
- Requesters, in priority order: the display scan-out path (reads tile colour from the hc/vc-derived tile address), a built-in clear engine (fills every tile with one colour, only during vertical blanking), and the game-logic writer.
- Sits between the tile address generator / VGA colour path and the framebuffer RAM macro.

---
 rtl/tile_fb_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tile_fb_controller.sv
// Tile framebuffer controller: arbitrates the single-port tile RAM between
// display scan-out, a vblank-only clear engine and the game-logic writer.
module tile_fb_controller #(
  parameter int unsigned TILES  = 768,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_oob,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_VB, RUN, DONE} clr_state_t;

  localparam logic [ADDR_W:0]   TILES_X = (ADDR_W+1)'(TILES);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(TILES - 1);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_col;
  logic              clr_use;
  logic              disp_bad, wr_bad;
  logic              rd_v1, rd_oob1;

  assign disp_bad = ({1'b0, disp_addr} >= TILES_X);
  assign wr_bad   = ({1'b0, wr_addr} >= TILES_X);

  // An out-of-range display read still wins the cycle; the RAM simply idles.
  always_comb begin
    disp_gnt  = disp_req;
    clr_use   = (state == RUN) && !disp_req;
    wr_gnt    = wr_req && !disp_req && !clr_use;
    wr_oob    = wr_gnt && wr_bad;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (disp_req) begin
      if (!disp_bad) begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end
    end else if (clr_use) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
      ram_wdata = clr_col;
    end else if (wr_gnt && !wr_bad) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = WAIT_VB;
      WAIT_VB: if (vblank) state_nxt = RUN;
      RUN: begin
        if (clr_use && clr_cnt == LAST) state_nxt = DONE;
        else if (!vblank)               state_nxt = WAIT_VB;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state != IDLE);
  assign clr_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      clr_col <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && clr_start) begin
        clr_col <= clr_color;
        clr_cnt <= '0;
      end else if (clr_use && clr_cnt != LAST) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
    end
  end

  // Two-stage read pipeline: RAM output lands in stage 1, registered in stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1      <= 1'b0;
      rd_oob1    <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      rd_v1      <= disp_req;
      rd_oob1    <= disp_req && disp_bad;
      disp_valid <= rd_v1;
      disp_data  <= (rd_v1 && !rd_oob1) ? ram_rdata : '0;
    end
  end

endmodule
